// File: rtl/mopshub_clk_pkg.sv
// Shared constants and divisor clamping for the MOPS-Hub clock tree.
package mopshub_clk_pkg;

    localparam int DIV_W = 28;
    localparam logic [DIV_W-1:0] MIN_DIV     = 28'd2;
    localparam logic [DIV_W-1:0] DEFAULT_DIV = 28'd4;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] n);
        return (n < MIN_DIV) ? MIN_DIV : n;
    endfunction

endpackage

// File: rtl/mopshub_clock_divider.sv
// Synchronous integer clock divider: registered divided clock, period tick,
// phase counter and a shadowed divisor that switches only at a period wrap.
module mopshub_clock_divider #(
    parameter int               DIV_W   = mopshub_clk_pkg::DIV_W,
    parameter logic [DIV_W-1:0] DIVISOR = DIV_W'(mopshub_clk_pkg::DEFAULT_DIV)
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             clock_out,
    output logic             tick,
    output logic [DIV_W-1:0] count,
    output logic [DIV_W-1:0] div_active
);
    import mopshub_clk_pkg::*;

    localparam int PW = mopshub_clk_pkg::DIV_W;

    function automatic logic [DIV_W-1:0] fit_div(input logic [DIV_W-1:0] v);
        return DIV_W'(clamp_div(PW'(v)));
    endfunction

    localparam logic [DIV_W-1:0] RST_DIV = fit_div(DIVISOR);

    logic             last;
    logic [DIV_W-1:0] count_next;
    logic [DIV_W-1:0] load_div;
    logic [DIV_W-1:0] pend_div;
    logic             pend_vld;

    always_comb begin
        last       = (count == div_active - DIV_W'(1));
        count_next = last ? '0 : count + DIV_W'(1);
        load_div   = fit_div(div_value);
    end

    // Wrap decision and outputs use the old divisor; a new one starts at count 0.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            div_active <= RST_DIV;
            count      <= RST_DIV - DIV_W'(1);
            clock_out  <= 1'b0;
            tick       <= 1'b0;
            pend_vld   <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                count     <= count_next;
                clock_out <= (count_next < (div_active >> 1));
                tick      <= last;
            end
            if (en && last) begin
                if (div_load) begin
                    div_active <= load_div;
                end else if (pend_vld) begin
                    div_active <= pend_div;
                end
                pend_vld <= 1'b0;
            end else if (div_load) begin
                pend_div <= load_div;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mopshub_clock_divider.sv
// Directed bench for mopshub_clock_divider with a queued reference scoreboard.
module tb_mopshub_clock_divider;

    localparam int DIV_W = 28;

    logic             clock_in;
    logic             rst;
    logic             en;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic             clock_out;
    logic             tick;
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] div_active;

    mopshub_clock_divider dut (
        .clock_in  (clock_in),
        .rst       (rst),
        .en        (en),
        .div_load  (div_load),
        .div_value (div_value),
        .clock_out (clock_out),
        .tick      (tick),
        .count     (count),
        .div_active(div_active)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    typedef struct {
        int clk;
        int tck;
        int cnt;
        int n;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_n, m_cnt, m_clk, m_tick, m_pv, m_pd;

    function automatic int clamp2(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit ld, input int val);
        bit wrap;
        int nxt;
        if (r) begin
            m_n = 4; m_cnt = 3; m_clk = 0; m_tick = 0; m_pv = 0;
        end else begin
            wrap   = (m_cnt + 1 == m_n);
            m_tick = 0;
            if (e) begin
                nxt    = wrap ? 0 : m_cnt + 1;
                m_clk  = (nxt < m_n / 2) ? 1 : 0;
                m_tick = wrap ? 1 : 0;
                m_cnt  = nxt;
            end
            if (e && wrap) begin
                if (ld) m_n = clamp2(val);
                else if (m_pv != 0) m_n = m_pd;
                m_pv = 0;
            end else if (ld) begin
                m_pd = clamp2(val);
                m_pv = 1;
            end
        end
    endtask

    // drive one cycle, push the expectation, then pop and compare after the edge
    task automatic step(input bit r, input bit e, input bit ld, input int val);
        exp_t x;
        rst       = r;
        en        = e;
        div_load  = ld;
        div_value = DIV_W'(val);
        model(r, e, ld, val);
        x.clk = m_clk; x.tck = m_tick; x.cnt = m_cnt; x.n = m_n;
        exp_q.push_back(x);
        @(posedge clock_in);
        #1;
        x = exp_q.pop_front();
        chk("clock_out", 32'(clock_out), 32'(x.clk));
        chk("tick", 32'(tick), 32'(x.tck));
        chk("count", 32'(count), 32'(x.cnt));
        chk("div_active", 32'(div_active), 32'(x.n));
    endtask

    int pat4[4]  = '{1, 1, 0, 0};
    int pat5[5]  = '{1, 1, 0, 0, 0};
    int tick4[4] = '{1, 0, 0, 0};

    initial begin
        rst = 1'b1; en = 1'b0; div_load = 1'b0; div_value = '0;

        // reset state
        step(1, 0, 0, 0);
        step(1, 1, 1, 9);
        chk("rst_div_active", 32'(div_active), 32'd4);
        chk("rst_count", 32'(count), 32'd3);
        chk("rst_clock_out", 32'(clock_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);

        // default divide-by-4: 1,1,0,0 with tick on each rise
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0);
            chk("n4_pattern", 32'(clock_out), 32'(pat4[i % 4]));
            chk("n4_tick", 32'(tick), 32'(tick4[i % 4]));
            chk("n4_count", 32'(count), 32'(i % 4));
        end

        // load 5 at reset release: applied at the first wrap edge
        step(1, 0, 0, 0);
        step(0, 1, 1, 5);
        chk("n5_first", 32'(clock_out), 32'd1);
        for (int i = 1; i < 15; i++) begin
            step(0, 1, 0, 0);
            chk("n5_pattern", 32'(clock_out), 32'(pat5[i % 5]));
        end
        chk("n5_div_active", 32'(div_active), 32'd5);

        // load 8 at count=1: current period stays 4, then 8 from the wrap
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("pre8_count", 32'(count), 32'd1);
        step(0, 1, 1, 8);
        step(0, 1, 0, 0);
        chk("pre8_div_active", 32'(div_active), 32'd4);
        step(0, 1, 0, 0);
        chk("wrap8_div_active", 32'(div_active), 32'd8);
        chk("wrap8_tick", 32'(tick), 32'd1);
        for (int i = 1; i < 16; i++) begin
            step(0, 1, 0, 0);
            chk("n8_pattern", 32'(clock_out), (i % 8 < 4) ? 32'd1 : 32'd0);
        end

        // clamp: 0 and 1 both become 2
        step(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        chk("clamp0_div_active", 32'(div_active), 32'd2);
        step(0, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        chk("clamp1_div_active", 32'(div_active), 32'd2);

        // enable hold at count=2
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("hold_count_pre", 32'(count), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("hold_count", 32'(count), 32'd2);
            chk("hold_tick", 32'(tick), 32'd0);
        end
        step(0, 1, 0, 0);
        chk("resume_count", 32'(count), 32'd3);
        step(0, 1, 0, 0);
        chk("resume_wrap", 32'(tick), 32'd1);

        // reset mid-period discards a pending load
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 6);
        step(1, 1, 0, 0);
        chk("abort_div_active", 32'(div_active), 32'd4);
        chk("abort_count", 32'(count), 32'd3);
        chk("abort_clock_out", 32'(clock_out), 32'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        chk("abort_discard", 32'(div_active), 32'd4);

        // mixed traffic against the model
        for (int i = 0; i < 120; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)));
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
